// File: rtl/missing_duplicated_word_pkg.sv
// missing_duplicated_word_pkg: shared word/index types, FSM states and sizing sanity flag for the checker and its generator.
package missing_duplicated_word_pkg;
  localparam int MDW_W = 5;
  localparam int MDW_N = 17;
  localparam int MDW_IW = $clog2(MDW_N);
  localparam bit MDW_CFG_OK = (MDW_N % 2 == 1) && ((MDW_N - 1) / 2 < 2 ** MDW_W);
  typedef logic [MDW_W-1:0] w_t;
  typedef logic [MDW_IW-1:0] id_t;
  localparam id_t MDW_N_ID = id_t'(MDW_N);
  localparam id_t MDW_LAST = id_t'(MDW_N - 1);
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_KICK, S_WAIT, S_REPORT} state_t;
endpackage

// File: rtl/mdw_gen_seq.sv
// mdw_gen_seq: write sequencer; registered index/data/last for write i, rotated index and paired data values.
module mdw_gen_seq
  import missing_duplicated_word_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic step,
  input  logic fault,
  input  w_t   u,
  input  id_t  r,
  output id_t  id,
  output w_t   dat,
  output logic last
);
  id_t i, i_n, id_n;
  always_comb begin
    i_n = load ? '0 : i + id_t'(1);
    id_n = load ? r : (id == MDW_LAST ? '0 : id + id_t'(1));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i <= '0;
      id <= '0;
      dat <= '0;
      last <= 1'b0;
    end else if (load || step) begin
      i <= i_n;
      id <= id_n;
      dat <= i_n == MDW_LAST ? (fault ? u + w_t'(1) : u) : u + w_t'(1) + w_t'(i_n >> 1);
      last <= i_n == MDW_LAST;
    end
  end
endmodule

// File: rtl/missing_duplicated_word_gen.sv
// missing_duplicated_word_gen: loads the checker with value pairs plus one singleton, kicks it and checks the answer.
// MISSING_DUPLICATED_WORD_GEN_FAULT_EN adds gen_fault, which replaces the singleton with a third copy of U+1.
module missing_duplicated_word_gen
  import missing_duplicated_word_pkg::*;
#(
  parameter int W = MDW_W,
  parameter int N = MDW_N
) (
  input  logic clk,
  input  logic rst,
  input  logic gen_start,
  input  w_t   gen_unique,
  input  id_t  gen_rot,
`ifdef MISSING_DUPLICATED_WORD_GEN_FAULT_EN
  input  logic gen_fault,
`endif
  output logic gen_busy_r,
  output logic gen_done_r,
  output logic gen_pass_r,
  output w_t   gen_result_r,
  output logic state_upt,
  output id_t  state_id,
  output w_t   state_dat,
  output logic cntrl_start,
  input  logic cntrl_busy_r,
  input  w_t   cntrl_dat_r
);
  if (W != MDW_W || N != MDW_N || !MDW_CFG_OK) begin : g_cfg_bad
    $error("missing_duplicated_word_gen: W/N must match the package, N odd and (N-1)/2 < 2**W");
  end
  state_t state, state_n;
  w_t u_q, u_sel;
  id_t r_sel;
  logic load, last, fault_sel, upt_n, kick_n, busy_n, done_n;
  assign load = state == S_IDLE && gen_start;
  assign u_sel = load ? gen_unique : u_q;
  assign r_sel = gen_rot >= MDW_N_ID ? '0 : gen_rot;
`ifdef MISSING_DUPLICATED_WORD_GEN_FAULT_EN
  logic fault_q;
  assign fault_sel = load ? gen_fault : fault_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fault_q <= 1'b0;
    else fault_q <= fault_sel;
  end
`else
  assign fault_sel = 1'b0;
`endif
  mdw_gen_seq u_seq (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (state == S_WRITE && !last),
    .fault(fault_sel),
    .u    (u_sel),
    .r    (r_sel),
    .id   (state_id),
    .dat  (state_dat),
    .last (last)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      u_q <= '0;
      gen_busy_r <= 1'b0;
      gen_done_r <= 1'b0;
      state_upt <= 1'b0;
      cntrl_start <= 1'b0;
      gen_pass_r <= 1'b0;
      gen_result_r <= '0;
    end else begin
      state <= state_n;
      u_q <= u_sel;
      gen_busy_r <= busy_n;
      gen_done_r <= done_n;
      state_upt <= upt_n;
      cntrl_start <= kick_n;
      if (state == S_WAIT && !cntrl_busy_r) begin
        gen_result_r <= cntrl_dat_r;
        gen_pass_r <= cntrl_dat_r == u_q;
      end
    end
  end
  always_comb begin
    state_n = state == S_IDLE  ? (gen_start ? S_WRITE : S_IDLE) :
              state == S_WRITE ? (last ? S_KICK : S_WRITE) :
              state == S_KICK  ? S_WAIT :
              state == S_WAIT  ? (cntrl_busy_r ? S_WAIT : S_REPORT) : S_IDLE;
  end
  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    upt_n = state_n == S_WRITE;
    kick_n = state_n == S_KICK;
    busy_n = state_n != S_IDLE;
    done_n = state_n == S_REPORT;
  end
endmodule

// File: tb/tb_missing_duplicated_word_gen.sv
// tb_missing_duplicated_word_gen: randomized runs against a spec-level write/result model with a behavioural checker stub.
module tb_missing_duplicated_word_gen;
  localparam int W = 5;
  localparam int N = 17;
  localparam int IW = $clog2(N);
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic gen_start = 1'b0;
  logic [W-1:0] gen_unique = '0;
  logic [IW-1:0] gen_rot = '0;
  logic gen_fault = 1'b0;
  logic gen_busy_r, gen_done_r, gen_pass_r, state_upt, cntrl_start;
  logic [W-1:0] gen_result_r, state_dat;
  logic [IW-1:0] state_id;
  logic cntrl_busy_r = 1'b0;
  logic [W-1:0] cntrl_dat_r = '0;
  logic [W-1:0] mem [N];
  int busy_cnt = 0;
  int compared = 0;
  int mismatched = 0;
  logic [W-1:0] prev_res = '0;
  logic prev_pass = 1'b0;

  always #5 clk = ~clk;

  missing_duplicated_word_gen dut (
    .clk         (clk),
    .rst         (rst),
    .gen_start   (gen_start),
    .gen_unique  (gen_unique),
    .gen_rot     (gen_rot),
`ifdef MISSING_DUPLICATED_WORD_GEN_FAULT_EN
    .gen_fault   (gen_fault),
`endif
    .gen_busy_r  (gen_busy_r),
    .gen_done_r  (gen_done_r),
    .gen_pass_r  (gen_pass_r),
    .gen_result_r(gen_result_r),
    .state_upt   (state_upt),
    .state_id    (state_id),
    .state_dat   (state_dat),
    .cntrl_start (cntrl_start),
    .cntrl_busy_r(cntrl_busy_r),
    .cntrl_dat_r (cntrl_dat_r)
  );

  function automatic logic [W-1:0] xor_mem();
    logic [W-1:0] x = '0;
    for (int j = 0; j < N; j++) x ^= mem[j];
    return x;
  endfunction

  // Checker stand-in: stores writes, stays busy N cycles after a kick, then returns the odd-count word.
  always @(posedge clk) begin
    if (state_upt) mem[state_id] <= state_dat;
    if (cntrl_start) begin
      busy_cnt <= N;
      cntrl_busy_r <= 1'b1;
      cntrl_dat_r <= W'($urandom);
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
      cntrl_dat_r <= W'($urandom);
    end else if (busy_cnt == 1) begin
      busy_cnt <= 0;
      cntrl_busy_r <= 1'b0;
      cntrl_dat_r <= xor_mem();
    end
  end

  // Called at a negedge; starts a run in that cycle (cycle 0) and returns at the negedge of cycle 2N+4.
  task automatic run(input string name, input logic [W-1:0] u, input int r, input bit fault,
                     input int extra1, input int extra2);
    int nwr = 0, nkick = 0, ndone = 0, bad_busy = 0, bad_hold = 0, rr, exp_id, exp_d;
    logic [W-1:0] exp_res;
    rr = r >= N ? 0 : r;
    exp_res = fault ? W'((int'(u) + 1) % (1 << W)) : u;
    gen_unique = u;
    gen_rot = IW'(r);
    gen_fault = fault;
    gen_start = 1'b1;
    for (int k = 1; k <= 2 * N + 4; k++) begin
      @(negedge clk);
      gen_start = (k == extra1 || k == extra2);
      if (state_upt) begin
        exp_id = (nwr + rr) % N;
        exp_d = nwr == N - 1 ? int'(exp_res) : (int'(u) + 1 + nwr / 2) % (1 << W);
        compared++;
        if (k != nwr + 1 || int'(state_id) != exp_id || int'(state_dat) != exp_d) begin
          mismatched++;
          $display("FAIL %s write%0d: cycle %0d id %0d dat %0d, want cycle %0d id %0d dat %0d",
                   name, nwr, k, state_id, state_dat, nwr + 1, exp_id, exp_d);
        end
        nwr++;
      end
      if (cntrl_start) begin
        nkick++;
        compared++;
        if (k != N + 1) begin
          mismatched++;
          $display("FAIL %s kick_cycle: got %0d want %0d", name, k, N + 1);
        end
      end
      if (gen_done_r) begin
        ndone++;
        compared++;
        if (k != 2 * N + 3) begin
          mismatched++;
          $display("FAIL %s done_cycle: got %0d want %0d", name, k, 2 * N + 3);
        end
      end
      if (gen_busy_r !== (k <= 2 * N + 3)) bad_busy++;
      if (k < 2 * N + 3 && (gen_result_r !== prev_res || gen_pass_r !== prev_pass)) bad_hold++;
      if (k == 2 * N + 3) begin
        compared++;
        if (gen_result_r !== exp_res || gen_pass_r !== !fault) begin
          mismatched++;
          $display("FAIL %s result: got %0d pass %0b, want %0d pass %0b",
                   name, gen_result_r, gen_pass_r, exp_res, !fault);
        end
      end
    end
    compared++;
    if (nwr != N || nkick != 1 || ndone != 1) begin
      mismatched++;
      $display("FAIL %s counts: writes %0d kicks %0d dones %0d, want %0d 1 1", name, nwr, nkick, ndone, N);
    end
    compared++;
    if (bad_busy != 0 || bad_hold != 0) begin
      mismatched++;
      $display("FAIL %s busy/hold: %0d busy errors %0d hold errors, want 0 0", name, bad_busy, bad_hold);
    end
    prev_res = exp_res;
    prev_pass = !fault;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    compared++;
    if ({gen_busy_r, gen_done_r, gen_pass_r, state_upt, cntrl_start, gen_result_r, state_id, state_dat} !== '0) begin
      mismatched++;
      $display("FAIL reset_values: busy %b done %b pass %b upt %b kick %b res %0d id %0d dat %0d, want all 0",
               gen_busy_r, gen_done_r, gen_pass_r, state_upt, cntrl_start, gen_result_r, state_id, state_dat);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run("u7_r0", 5'd7, 0, 1'b0, -1, -1);
    run("u31_r16", 5'd31, 16, 1'b0, -1, -1);
  endtask

  task automatic test_rot_out_of_range();
    run("u7_r20", 5'd7, 20, 1'b0, -1, -1);
    run("u12_r31", 5'd12, 31, 1'b0, -1, -1);
  endtask

  task automatic test_start_ignored();
    run("start_mid_run", 5'd20, 3, 1'b0, 5, 20);
  endtask

  task automatic test_back_to_back();
    run("b2b_first", 5'd1, 9, 1'b0, 2 * N + 3, -1);
    run("b2b_second", 5'd25, 4, 1'b0, -1, -1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) run("random", W'($urandom), int'($urandom_range(0, 31)), 1'b0, -1, -1);
  endtask

  task automatic test_reset_mid_write();
    gen_unique = 5'd9;
    gen_rot = '0;
    gen_start = 1'b1;
    @(negedge clk);
    gen_start = 1'b0;
    repeat (6) @(negedge clk);
    compared++;
    if (state_upt !== 1'b1 || state_id !== IW'(6)) begin
      mismatched++;
      $display("FAIL mid_write_pre: upt %b id %0d, want 1 6", state_upt, state_id);
    end
    rst = 1'b1;
    #1;
    compared++;
    if ({gen_busy_r, gen_done_r, gen_pass_r, state_upt, cntrl_start, gen_result_r, state_id, state_dat} !== '0) begin
      mismatched++;
      $display("FAIL mid_write_reset: busy %b upt %b id %0d dat %0d res %0d, want all 0",
               gen_busy_r, state_upt, state_id, state_dat, gen_result_r);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if (gen_busy_r !== 1'b0 || state_upt !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_write_idle: busy %b upt %b, want 0 0", gen_busy_r, state_upt);
    end
    prev_res = '0;
    prev_pass = 1'b0;
    run("after_reset_u3", 5'd3, int'($urandom_range(0, 16)), 1'b0, -1, -1);
  endtask

  task automatic test_fault();
`ifdef MISSING_DUPLICATED_WORD_GEN_FAULT_EN
    run("fault_u7", 5'd7, 0, 1'b1, -1, -1);
    run("fault_clear", 5'd7, 0, 1'b0, -1, -1);
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rot_out_of_range();
    test_start_ignored();
    test_back_to_back();
    test_random();
    test_reset_mid_write();
    test_fault();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
